// File: rtl/sid_pkg.sv
// Shared definitions for the SID combined-waveform table path.
package sid_pkg;

   // Waveform table ids, as carried in the frame select byte
   localparam logic [1:0] TBL_PS  = 2'd0;
   localparam logic [1:0] TBL_PST = 2'd1;
   localparam logic [1:0] TBL_PT  = 2'd2;
   localparam logic [1:0] TBL_ST  = 2'd3;

   // Frame start byte
   localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      SEL,
      DATA,
      CHECK,
      DONE
   } loader_state_t;

endpackage

// File: rtl/sid_table_loader.sv
// Writer side of the SID combined-waveform tables: parses a framed byte
// stream, writes one table through a registered RAM write port, checks an
// 8-bit additive checksum and keeps a per-table valid mask.
module sid_table_loader
   import sid_pkg::*;
#(
   parameter int unsigned ADDR_BITS  = 12,
   parameter logic [7:0]  MAGIC      = MAGIC_DEFAULT,
   parameter int unsigned TABLE_BITS = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [7:0]                   in_data,
   output logic                         in_ready,
   input  logic                         abort,
   output logic                         wr_en,
   output logic [TABLE_BITS-1:0]        wr_table,
   output logic [ADDR_BITS-1:0]         wr_addr,
   output logic [7:0]                   wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         error,
   output logic [(1<<TABLE_BITS)-1:0]   valid_mask
);

   loader_state_t         state;
   logic [TABLE_BITS-1:0] table_id;
   logic [ADDR_BITS-1:0]  count;
   logic [7:0]            sum;
   logic                  xfer;

   // abort wins over a same-cycle byte, so that byte never counts as a transfer
   assign xfer = in_valid & in_ready & ~abort;

   // Frame FSM with the write port and all status outputs registered here
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         table_id   <= '0;
         count      <= '0;
         sum        <= '0;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_table   <= '0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         valid_mask <= '0;
      end else begin
         wr_en    <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b1;
         if (abort && (state == SEL || state == DATA || state == CHECK)) begin
            // Mask bit for the table was already cleared on entry to DATA
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (xfer && in_data == MAGIC) begin
                     error <= 1'b0;
                     busy  <= 1'b1;
                     state <= SEL;
                  end
               end
               SEL: begin
                  if (xfer) begin
                     if ((in_data >> TABLE_BITS) != 8'd0) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        table_id                          <= in_data[TABLE_BITS-1:0];
                        valid_mask[in_data[TABLE_BITS-1:0]] <= 1'b0;
                        sum                               <= '0;
                        count                             <= '0;
                        state                             <= DATA;
                     end
                  end
               end
               DATA: begin
                  if (xfer) begin
                     wr_en    <= 1'b1;
                     wr_table <= table_id;
                     wr_addr  <= count;
                     wr_data  <= in_data;
                     count    <= count + 1'b1;
                     sum      <= sum + in_data;
                     // Last entry: the counter wraps back to 0 on this byte
                     if (count == '1) begin
                        state <= CHECK;
                     end
                  end
               end
               CHECK: begin
                  if (xfer) begin
                     if (in_data == sum) begin
                        valid_mask[table_id] <= 1'b1;
                        done                 <= 1'b1;
                     end else begin
                        error <= 1'b1;
                     end
                     busy     <= 1'b0;
                     in_ready <= 1'b0;
                     state    <= DONE;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
